bank_arbiter: RTL

BANK_ARBITER -- requirements
Module: bank_arbiter

---
 rtl/bank_arb_pkg.sv | 21 ++
 rtl/bank_arbiter_rr_arb.sv | 45 ++++
 rtl/bank_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/bank_arb_pkg.sv
// Shared defaults and packed-slice helpers for the bank arbiter.
package bank_arb_pkg;

    localparam int unsigned NUM_REQ_DEF = 3;
    localparam int unsigned ADDR_W_DEF  = 7;
    localparam int unsigned DATA_W_DEF  = 128;

    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

    function automatic int unsigned slice_hi(input int unsigned idx, input int unsigned width);
        return idx * width + width - 1;
    endfunction

    // Pointer width that stays legal for a single requester.
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bank_arbiter_rr_arb.sv
// Round-robin arbiter: one-hot grant from a rotating priority pointer that
// advances past the winner only when the caller confirms the accept.
module rr_arb
    import bank_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic                          i_accept,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic                          o_found,
    output logic [ptr_w(NUM_REQ)-1:0]     o_idx
);

    localparam int unsigned PTR_W = ptr_w(NUM_REQ);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_found = 1'b0;
        o_idx   = '0;
        w_pos   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_pos = PTR_W'((32'(r_ptr) + k) % NUM_REQ);
            if (!o_found && i_req[w_pos]) begin
                o_found        = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr <= '0;
        end else if (i_accept) begin
            r_ptr <= (o_idx == PTR_W'(NUM_REQ - 1)) ? '0 : o_idx + 1'b1;
        end
    end

endmodule

// File: rtl/bank_arbiter.sv
// Multi-requester front end for a single-port-per-direction memory bank:
// independent write and read round-robin arbiters with a same-address hazard guard.
module bank_arbiter
    import bank_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF
) (
    input  logic                        vsi_clk,
    input  logic                        vsi_reset,
    input  logic [NUM_REQ-1:0]          vsi_req_valid,
    input  logic [NUM_REQ-1:0]          vsi_req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   vsi_req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   vsi_req_wdata,
    output logic [NUM_REQ-1:0]          vsi_req_ready,
    output logic [NUM_REQ-1:0]          vsi_rsp_valid,
    output logic [DATA_W-1:0]           vsi_rsp_data,
    output logic [DATA_W-1:0]           vsi_inputData,
    output logic [ADDR_W-1:0]           vsi_inputAddr,
    output logic                        vsi_inputChipSelect,
    output logic [ADDR_W-1:0]           vsi_outputAddr,
    output logic                        vsi_outputChipSelect,
    input  logic [DATA_W-1:0]           vsi_outputData
);

    localparam int unsigned PTR_W = ptr_w(NUM_REQ);

    logic                 w_run;
    logic [NUM_REQ-1:0]   w_wr_req;
    logic [NUM_REQ-1:0]   w_rd_req;
    logic [NUM_REQ-1:0]   w_wr_grant;
    logic [NUM_REQ-1:0]   w_rd_grant;
    logic                 w_wr_found;
    logic                 w_rd_found;
    logic [PTR_W-1:0]     w_wr_idx;
    logic [PTR_W-1:0]     w_rd_idx;
    logic [ADDR_W-1:0]    w_wr_addr;
    logic [DATA_W-1:0]    w_wr_data;
    logic [ADDR_W-1:0]    w_rd_addr;
    logic                 w_hazard;
    logic                 w_rd_accept;

    logic                 r_wr_cs;
    logic [ADDR_W-1:0]    r_wr_addr;
    logic [DATA_W-1:0]    r_wr_data;
    logic                 r_rd_cs;
    logic [ADDR_W-1:0]    r_rd_addr;
    logic [NUM_REQ-1:0]   r_rd_id;
    logic [NUM_REQ-1:0]   r_rsp_id;

    assign w_run    = ~vsi_reset;
    assign w_wr_req = vsi_req_valid & vsi_req_write & {NUM_REQ{w_run}};
    assign w_rd_req = vsi_req_valid & ~vsi_req_write & {NUM_REQ{w_run}};

    rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_wr_arb (
        .i_clk    (vsi_clk),
        .i_reset  (vsi_reset),
        .i_req    (w_wr_req),
        .i_accept (w_wr_found),
        .o_grant  (w_wr_grant),
        .o_found  (w_wr_found),
        .o_idx    (w_wr_idx)
    );

    rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_rd_arb (
        .i_clk    (vsi_clk),
        .i_reset  (vsi_reset),
        .i_req    (w_rd_req),
        .i_accept (w_rd_accept),
        .o_grant  (w_rd_grant),
        .o_found  (w_rd_found),
        .o_idx    (w_rd_idx)
    );

    assign w_wr_addr = vsi_req_addr[slice_lo(32'(w_wr_idx), ADDR_W) +: ADDR_W];
    assign w_wr_data = vsi_req_wdata[slice_lo(32'(w_wr_idx), DATA_W) +: DATA_W];
    assign w_rd_addr = vsi_req_addr[slice_lo(32'(w_rd_idx), ADDR_W) +: ADDR_W];

    // A read racing a same-address write waits so it observes the new data.
    assign w_hazard    = w_wr_found & w_rd_found & (w_wr_addr == w_rd_addr);
    assign w_rd_accept = w_rd_found & ~w_hazard;

    assign vsi_req_ready = w_wr_grant | (w_rd_grant & {NUM_REQ{~w_hazard}});

    always_ff @(posedge vsi_clk) begin
        if (vsi_reset) begin
            r_wr_cs   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_rd_cs   <= 1'b0;
            r_rd_addr <= '0;
            r_rd_id   <= '0;
            r_rsp_id  <= '0;
        end else begin
            r_wr_cs <= w_wr_found;
            if (w_wr_found) begin
                r_wr_addr <= w_wr_addr;
                r_wr_data <= w_wr_data;
            end
            r_rd_cs <= w_rd_accept;
            if (w_rd_accept) begin
                r_rd_addr <= w_rd_addr;
            end
            // One-hot owner ID tracks the bank's one-cycle read latency.
            r_rd_id  <= w_rd_accept ? w_rd_grant : '0;
            r_rsp_id <= r_rd_id;
        end
    end

    // Outputs are forced quiet while reset is held, including its first cycle.
    assign vsi_inputChipSelect  = r_wr_cs & w_run;
    assign vsi_inputAddr        = w_run ? r_wr_addr : '0;
    assign vsi_inputData        = w_run ? r_wr_data : '0;
    assign vsi_outputChipSelect = r_rd_cs & w_run;
    assign vsi_outputAddr       = w_run ? r_rd_addr : '0;
    assign vsi_rsp_valid        = r_rsp_id & {NUM_REQ{w_run}};
    assign vsi_rsp_data         = (w_run && (|r_rsp_id)) ? vsi_outputData : '0;

endmodule
